// File: rtl/ssd_pkg.sv
// Shared types, constants and helper functions for the seven-segment scan blocks.
// Latency: pure combinational helpers, no state.
// Backpressure: not applicable (no handshakes).
package ssd_pkg;

    // Width of one digit code on the shared bus
    localparam int DIGIT_W    = 4;
    // Widest display supported; helpers work on this width and callers slice down
    localparam int MAX_DIGITS = 8;
    localparam int IDX_MAX_W  = 3;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Anodes are low-active, so "everything dark" is all ones
    localparam logic [MAX_DIGITS-1:0] ALL_OFF = '1;

    // All anodes off except bit idx (within the first n digits), which is pulled low
    function automatic logic [MAX_DIGITS-1:0] onehot_low(input logic [IDX_MAX_W-1:0] idx,
                                                         input int n);
        logic [MAX_DIGITS-1:0] r;
        r = ALL_OFF;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if ((k < n) && (idx == IDX_MAX_W'(k))) begin
                r[k] = 1'b0;
            end
        end
        return r;
    endfunction

    // Bit k set when digit k is a leading zero: k>0 and digits k..n-1 are all zero.
    // Walks from the most significant digit down, keeping a running "still zero" flag.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [DIGIT_W*MAX_DIGITS-1:0] digits,
                                                      input int n);
        logic [MAX_DIGITS-1:0] m;
        logic                  zero_run;
        m        = '0;
        zero_run = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            if (k < n) begin
                zero_run = zero_run & (digits[DIGIT_W*k +: DIGIT_W] == digit_t'(0));
                m[k]     = (k > 0) && zero_run;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ssd_scan_prescaler.sv
// Free-running refresh divider: counts 0..DIV-1, flags the last and first cycle of each window.
// Latency: adv and cnt_is_zero decode the registered count directly (no extra delay).
// Backpressure: none; runs every cycle while out of reset.
module ssd_scan_prescaler
    import ssd_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic adv,
    output logic cnt_is_zero
);

    // A one-cycle window still needs a 1-bit counter that simply stays at zero
    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign adv         = (cnt_q == CNT_LAST);
    assign cnt_is_zero = (cnt_q == '0);

    // Next count: wrap to zero at the end of the window
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (adv) begin
            cnt_d = '0;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ssd_scan_ctl_n.sv
// Self-timed N-digit common-anode scan controller with blanking, DP and dead time.
// Latency: outputs registered, one cycle after the (scan_idx, count, inputs) they reflect.
// Backpressure: none; free-running scan, inputs sampled every cycle without latching.
module ssd_scan_ctl_n
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          lz_blank,
    output logic [DIGIT_W-1:0]            intossd,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         lightctl,
    output logic [IDX_W-1:0]              scan_idx,
    output logic                          frame_tick
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    // With a single-cycle window there is no room for a dark gap
    localparam bit               HAS_DEAD = (DIV >= 2);

    logic adv;
    logic cnt_is_zero;

    logic [IDX_W-1:0]              scan_idx_q;
    logic [IDX_W-1:0]              scan_idx_d;
    logic                          frame_tick_q;
    logic                          frame_tick_d;
    logic [NUM_DIGITS-1:0]         lightctl_q;
    logic [NUM_DIGITS-1:0]         lightctl_d;
    logic [DIGIT_W-1:0]            intossd_q;
    logic [DIGIT_W-1:0]            intossd_d;
    logic                          dp_q;
    logic                          dp_d;

    logic [DIGIT_W*MAX_DIGITS-1:0] digits_pad;
    logic [MAX_DIGITS-1:0]         blank_mask;
    logic [MAX_DIGITS-1:0]         anode_sel;
    digit_t                        cur_code;
    logic                          cur_en;
    logic                          cur_dp;
    logic                          cur_blank;
    logic                          show;
    logic                          unused_bits;

    ssd_scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .adv         (adv),
        .cnt_is_zero (cnt_is_zero)
    );

    // Helpers work at the maximum width; only the low NUM_DIGITS bits matter here
    assign unused_bits = ^{blank_mask, anode_sel};

    // Digit index steps at the end of each window and wraps before any unused code
    always_comb begin
        scan_idx_d   = scan_idx_q;
        frame_tick_d = 1'b0;
        if (adv) begin
            if (scan_idx_q == LAST_IDX) begin
                scan_idx_d   = '0;
                frame_tick_d = 1'b1;
            end else begin
                scan_idx_d = scan_idx_q + IDX_W'(1);
            end
        end
    end

    // Leading-zero mask over the whole display, gated by lz_blank
    always_comb begin
        digits_pad                         = '0;
        digits_pad[DIGIT_W*NUM_DIGITS-1:0] = digits_in;
        blank_mask                         = '0;
        if (lz_blank) begin
            blank_mask = lz_mask(digits_pad, NUM_DIGITS);
        end
    end

    // Pick the code, enable, DP and blank flag of the digit in the current window
    always_comb begin
        cur_code  = '0;
        cur_en    = 1'b0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx_q == IDX_W'(k)) begin
                cur_code  = digits_in[DIGIT_W*k +: DIGIT_W];
                cur_en    = digit_en[k];
                cur_dp    = dp_in[k];
                cur_blank = blank_mask[k];
            end
        end
    end

    // Next output values: dark during the dead-time cycle or when the digit is not lit
    always_comb begin
        anode_sel  = onehot_low(IDX_MAX_W'(scan_idx_q), NUM_DIGITS);
        show       = cur_en && !cur_blank && !(HAS_DEAD && cnt_is_zero);
        lightctl_d = ALL_OFF[NUM_DIGITS-1:0];
        intossd_d  = '0;
        dp_d       = 1'b0;
        if (show) begin
            lightctl_d = anode_sel[NUM_DIGITS-1:0];
            intossd_d  = cur_code;
            dp_d       = cur_dp;
        end
    end

    // Scan state and output registers; reset leaves the display dark at digit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_q   <= '0;
            frame_tick_q <= 1'b0;
            lightctl_q   <= ALL_OFF[NUM_DIGITS-1:0];
            intossd_q    <= '0;
            dp_q         <= 1'b0;
        end else begin
            scan_idx_q   <= scan_idx_d;
            frame_tick_q <= frame_tick_d;
            lightctl_q   <= lightctl_d;
            intossd_q    <= intossd_d;
            dp_q         <= dp_d;
        end
    end

    assign scan_idx   = scan_idx_q;
    assign frame_tick = frame_tick_q;
    assign lightctl   = lightctl_q;
    assign intossd    = intossd_q;
    assign dp_out     = dp_q;

endmodule

// File: tb/tb_ssd_scan_ctl_n.sv
// Directed bench for the scan controller with a cycle-level scoreboard model.
// Latency: expectations pushed at each active edge, compared at the following falling edge.
// Backpressure: not applicable; the bench drives inputs on falling edges only.
module tb_ssd_scan_ctl_n;

    typedef struct packed {
        logic [3:0] light;
        logic [3:0] code;
        logic       dp;
        logic       ft;
        logic [1:0] idx;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  intossd;
    logic        dp_out;
    logic [3:0]  lightctl;
    logic [1:0]  scan_idx;
    logic        frame_tick;

    logic        rst1_n;
    logic [11:0] d1_digits;
    logic [2:0]  d1_en;
    logic [2:0]  d1_dp;
    logic        d1_lz;
    logic [3:0]  d1_intossd;
    logic        d1_dp_out;
    logic [2:0]  d1_lightctl;
    logic [1:0]  d1_scan_idx;
    logic        d1_frame_tick;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t sb[$];
    logic [1:0] m_cnt;
    logic [1:0] m_idx;

    ssd_scan_ctl_n #(.NUM_DIGITS(4), .DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .intossd    (intossd),
        .dp_out     (dp_out),
        .lightctl   (lightctl),
        .scan_idx   (scan_idx),
        .frame_tick (frame_tick)
    );

    ssd_scan_ctl_n #(.NUM_DIGITS(3), .DIV(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst1_n),
        .digits_in  (d1_digits),
        .digit_en   (d1_en),
        .dp_in      (d1_dp),
        .lz_blank   (d1_lz),
        .intossd    (d1_intossd),
        .dp_out     (d1_dp_out),
        .lightctl   (d1_lightctl),
        .scan_idx   (d1_scan_idx),
        .frame_tick (d1_frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference for the 4-digit, DIV=4 instance, straight from the behavioural description
    function automatic exp_t model(input logic [1:0] idx, input logic [1:0] cnt,
                                   input logic [15:0] d, input logic [3:0] en,
                                   input logic [3:0] dp, input logic lz);
        exp_t r;
        bit   blank;
        bit   on;
        blank = 1'b0;
        if (lz && idx != 2'd0) begin
            blank = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (j >= int'(idx) && d[4*j +: 4] != 4'h0) blank = 1'b0;
            end
        end
        on      = en[idx] && !blank && (cnt != 2'd0);
        r.light = on ? ~(4'b0001 << idx) : 4'b1111;
        r.code  = on ? d[4*idx +: 4] : 4'h0;
        r.dp    = on && dp[idx];
        r.ft    = (cnt == 2'd3) && (idx == 2'd3);
        r.idx   = (cnt == 2'd3) ? idx + 2'd1 : idx;
        return r;
    endfunction

    task automatic chk_sb(input exp_t e);
        chk("sb_light", lightctl, e.light);
        chk("sb_code", intossd, e.code);
        chk("sb_dp", dp_out, e.dp);
        chk("sb_ft", frame_tick, e.ft);
        chk("sb_idx", scan_idx, e.idx);
    endtask

    // Scoreboard producer: predict what the next edge registers
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 2'd0;
            m_idx <= 2'd0;
            sb.delete();
        end else begin
            sb.push_back(model(m_idx, m_cnt, digits_in, digit_en, dp_in, lz_blank));
            m_cnt <= m_cnt + 2'd1;
            if (m_cnt == 2'd3) m_idx <= m_idx + 2'd1;
        end
    end

    // Scoreboard consumer
    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) chk_sb(sb.pop_front());
    end

    // One full frame from a frame boundary, from directed expectations
    task automatic check_16(input string tag, input logic [3:0] lit,
                            input logic [15:0] codes, input logic [3:0] dpx);
        for (int i = 0; i < 16; i++) begin
            int         w;
            int         ph;
            logic       on;
            logic [3:0] exp_l;
            logic [1:0] exp_i;
            @(negedge clk);
            w     = i / 4;
            ph    = i % 4;
            on    = lit[w] && (ph != 0);
            exp_l = 4'b1111;
            if (on) exp_l[w] = 1'b0;
            exp_i = (ph == 3) ? 2'(w + 1) : 2'(w);
            chk({tag, "_light"}, lightctl, exp_l);
            chk({tag, "_code"}, intossd, on ? {28'd0, codes[4*w +: 4]} : 32'd0);
            chk({tag, "_dp"}, dp_out, on && dpx[w]);
            chk({tag, "_ft"}, frame_tick, i == 15);
            chk({tag, "_idx"}, scan_idx, exp_i);
        end
    endtask

    initial begin
        logic       got;
        logic [2:0] e3;
        rst_n     = 1'b0;
        rst1_n    = 1'b0;
        digits_in = 16'h1234;
        digit_en  = 4'hF;
        dp_in     = 4'h0;
        lz_blank  = 1'b0;
        d1_digits = 12'h321;
        d1_en     = 3'b111;
        d1_dp     = 3'b000;
        d1_lz     = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_light", lightctl, 4'hF);
        chk("rst_code", intossd, 4'h0);
        chk("rst_dp", dp_out, 1'b0);
        chk("rst_ft", frame_tick, 1'b0);
        chk("rst_idx", scan_idx, 2'd0);
        chk("rst1_light", d1_lightctl, 3'b111);

        // Basic scan, two consecutive frames
        rst_n = 1'b1;
        check_16("basic", 4'hF, 16'h1234, 4'h0);
        check_16("basic2", 4'hF, 16'h1234, 4'h0);

        // Leading-zero blanking
        digits_in = 16'h0050;
        lz_blank  = 1'b1;
        check_16("lz", 4'b0011, 16'h0050, 4'h0);
        digits_in = 16'h0000;
        check_16("lz0", 4'b0001, 16'h0000, 4'h0);

        // Per-digit enable and decimal point
        digits_in = 16'h89AB;
        lz_blank  = 1'b0;
        digit_en  = 4'b0101;
        dp_in     = 4'b0100;
        check_16("endp", 4'b0101, 16'h89AB, 4'b0100);

        // Input change mid-window
        digits_in = 16'h1234;
        digit_en  = 4'hF;
        dp_in     = 4'h0;
        repeat (2) @(negedge clk);
        chk("mid_before", intossd, 4'h4);
        digits_in = 16'h1237;
        #1;
        chk("mid_hold", intossd, 4'h4);
        @(negedge clk);
        chk("mid_code", intossd, 4'h7);
        chk("mid_light", lightctl, 4'b1110);

        // Reset in the middle of the digit-2 window
        digits_in = 16'h1234;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (scan_idx == 2'd2) got = 1'b1;
        end
        chk("wait_idx2", got, 1'b1);
        repeat (2) @(negedge clk);
        chk("pre_rst_light", lightctl, 4'b1011);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_light", lightctl, 4'hF);
        chk("mrst_code", intossd, 4'h0);
        chk("mrst_ft", frame_tick, 1'b0);
        chk("mrst_dp", dp_out, 1'b0);
        chk("mrst_idx", scan_idx, 2'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_16("post_rst", 4'hF, 16'h1234, 4'h0);

        // DIV=1, three digits: no dead time, index advances every clock
        rst1_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            int j;
            @(negedge clk);
            j     = (k - 1) % 3;
            e3    = 3'b111;
            e3[j] = 1'b0;
            chk("div1_light", d1_lightctl, e3);
            chk("div1_code", d1_intossd, j + 1);
            chk("div1_idx", d1_scan_idx, k % 3);
            chk("div1_ft", d1_frame_tick, (k % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctl_n.md
Name: ssd_scan_ctl_n

Overview:
Parametrised, self-timed scan controller for an N-digit, common-anode seven-segment display.
- Contains its own refresh prescaler and digit index counter; no external selector is needed.
- Time-multiplexes N 4-bit digit codes onto one shared bus, together with low-active digit enables.
- Adds per-digit enable, decimal point, leading-zero blanking and anti-ghosting dead time.
- Sits between the datapath (counters/BCD registers) and the downstream 4-bit-to-segment decoder.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
DIV, 50000, clock cycles per digit window (>=1); 100 MHz/50000 = 2 kHz per digit
IDX_W, $clog2(NUM_DIGITS), digit index width (derived, not overridden)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
digits_in  input  4*NUM_DIGITS  digit codes; digit k = bits [4k+3:4k], digit 0 = rightmost/least significant
digit_en  input  NUM_DIGITS  1 = digit k may light
dp_in  input  NUM_DIGITS  decimal point request per digit
lz_blank  input  1  1 = suppress leading zeros
intossd  output  4  code of the currently lit digit, to the segment decoder
dp_out  output  1  decimal point for the current digit, active-high
lightctl  output  NUM_DIGITS  digit anodes, low-active, at most one bit low
scan_idx  output  IDX_W  index of the digit window currently being driven
frame_tick  output  1  one-cycle pulse per completed scan frame

Behaviour:
- Reset (asynchronous, while rst_n=0): prescaler=0, scan_idx=0, lightctl=all ones, intossd=0, dp_out=0, frame_tick=0. Release starts a fresh frame at digit 0.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - adv = (cnt==DIV-1).
  - On adv, scan_idx increments; it wraps from NUM_DIGITS-1 to 0. With non-power-of-2 NUM_DIGITS, scan_idx never reaches an unused code.
- Digit window: each window lasts exactly DIV cycles. The frame period is NUM_DIGITS*DIV cycles.
- frame_tick: registered; high for exactly the one cycle in which scan_idx holds 0 after wrapping from NUM_DIGITS-1. No pulse occurs on the first window after reset.
- Blanking of digit k (only when lz_blank=1): digit k is blanked iff k>0 and all digits k..NUM_DIGITS-1 equal 4'h0. Digit 0 is never zero-suppressed.
- Digit k is lit iff digit_en[k]=1 and digit k is not blanked.
- Output stage:
  - Registered outputs with one-cycle latency. At edge t, outputs take the function of (scan_idx, cnt, inputs) sampled at t.
  - Dead time: when cnt==0 and DIV>=2, the registered lightctl is all ones, intossd=0 and dp_out=0. When DIV=1 there is no dead time.
  - Lit digit: lightctl = all ones with bit scan_idx cleared; intossd = digit code (raw 4 bits, A-F passed through); dp_out = dp_in[scan_idx].
  - Unlit digit: lightctl = all ones; intossd = 0; dp_out = 0.
- Input changes mid-window take effect one cycle later. No input latching per window.
- Reset mid-window: all outputs go to their reset values immediately. Release restarts at digit 0, cnt=0.

Decomposition:
- Package ssd_pkg:
  - DIGIT_W=4
  - constant ALL_OFF (lightctl all ones, sized by function)
  - function onehot_low(idx, n)
  - function lz_mask(digits, n)
- Sub-module ssd_scan_prescaler(clk, rst_n, adv, cnt_is_zero), parameter DIV. This is the shared refresh divider, reused by other display blocks.
- The top level holds scan_idx, the blanking logic and the output registers.

Test Plan:
- Basic scan, NUM_DIGITS=4, DIV=4, digits_in=16'h1234, digit_en=4'hF, lz_blank=0: lightctl repeats 1111,1110,1110,1110 / 1111,1101,1101,1101 / 1111,1011x3 / 1111,0111x3. intossd shows 4,3,2,1 in the lit cycles. frame_tick pulses once every 16 cycles.
- Leading zero, digits_in=16'h0050, lz_blank=1: digit windows 3 and 2 show lightctl=1111. Digit 1 lit with intossd=5; digit 0 lit with intossd=0. With digits_in=16'h0000, only digit 0 lights, showing 0.
- Enable/DP, digit_en=4'b0101, dp_in=4'b0100, digits_in=16'h89AB: only digits 0 (B) and 2 (9) light. dp_out=1 only in digit 2 lit cycles.
- DIV=1, NUM_DIGITS=3: scan_idx cycles 0,1,2,0 each clock. No dead time; lightctl 110,101,011 repeating. frame_tick asserts once every 3 cycles.
- Reset mid-scan: drop rst_n during the scan_idx=2 window. Outputs immediately read lightctl=1111, intossd=0, frame_tick=0. After release, first window is digit 0 and the first frame_tick occurs NUM_DIGITS*DIV cycles later.
- Input change mid-window: change digits_in nibble 0 from 4 to 7 mid-window. intossd reads 7 one cycle later, with no glitch on lightctl.
